// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3 encodings of the RV32M instructions
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int         MD_ITER   = 32;
  localparam logic [5:0] MD_LAST   = 6'(MD_ITER - 1);

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One combinational radix-2 iteration: shift-add multiply or
//               restoring shift-subtract divide on unsigned magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [31:0] operand,
  input  logic [31:0] mcand_div,
  input  logic        div_class,
  output logic [31:0] acc_next,
  output logic [31:0] operand_next
);

  logic [32:0] w_sum;
  logic [32:0] w_shifted;
  logic [32:0] w_diff;

  always_comb begin
    w_sum        = {1'b0, acc} + {1'b0, mcand_div};
    w_shifted    = {acc, operand[31]};
    w_diff       = w_shifted - {1'b0, mcand_div};
    acc_next     = acc;
    operand_next = operand;
    if (div_class) begin
      // acc holds the partial remainder; operand shifts dividend out, quotient in
      if (w_shifted >= {1'b0, mcand_div}) begin
        acc_next     = w_diff[31:0];
        operand_next = {operand[30:0], 1'b1};
      end else begin
        acc_next     = w_shifted[31:0];
        operand_next = {operand[30:0], 1'b0};
      end
    end else if (operand[0]) begin
      // {acc, operand} is the 64-bit product shifting right one bit per step
      acc_next     = w_sum[32:1];
      operand_next = {w_sum[0], operand[31:1]};
    end else begin
      acc_next     = {1'b0, acc[31:1]};
      operand_next = {acc[0], operand[31:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               Optional MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MulDivE,
  input  logic [2:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [31:0] MulDivResult
);

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_count;
  logic [31:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_divisor;
  logic [2:0]  r_op;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_accept;
  logic        w_div_op;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_overflow;
  logic        w_fast_mul;
  logic        w_short;
  logic [31:0] w_short_result;
  logic [31:0] w_step_acc;
  logic [31:0] w_step_opnd;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  assign w_accept   = (r_state == IDLE) && MulDivE && !FlushE;
  assign w_div_op   = MulDivOpE[2];
  assign w_a_signed = (MulDivOpE == OP_MULH) || (MulDivOpE == OP_MULHSU) ||
                      (MulDivOpE == OP_DIV)  || (MulDivOpE == OP_REM);
  assign w_b_signed = (MulDivOpE == OP_MULH) || (MulDivOpE == OP_DIV) ||
                      (MulDivOpE == OP_REM);
  assign w_a_neg    = w_a_signed && SrcAE[31];
  assign w_b_neg    = w_b_signed && SrcBE[31];
  assign w_a_mag    = w_a_neg ? (~SrcAE + 32'd1) : SrcAE;
  assign w_b_mag    = w_b_neg ? (~SrcBE + 32'd1) : SrcBE;
  assign w_div_zero = w_div_op && (SrcBE == 32'd0);
  assign w_overflow = ((MulDivOpE == OP_DIV) || (MulDivOpE == OP_REM)) &&
                      (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] w_fa;
  logic signed [63:0] w_fb;
  logic signed [63:0] w_fprod;
  // 33-bit signed operands, extended so the product is taken at 64 bits
  assign w_fa       = {{32{w_a_signed & SrcAE[31]}}, SrcAE};
  assign w_fb       = {{32{w_b_signed & SrcBE[31]}}, SrcBE};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast_mul = !w_div_op;
`else
  assign w_fast_mul = 1'b0;
`endif

  assign w_short = w_div_zero || w_overflow || w_fast_mul;

  always_comb begin
    w_short_result = 32'd0;
    if (w_div_zero)
      w_short_result = MulDivOpE[1] ? SrcAE : 32'hFFFF_FFFF;
    else if (w_overflow)
      w_short_result = MulDivOpE[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    else if (w_fast_mul)
      w_short_result = (MulDivOpE == OP_MUL) ? w_fprod[31:0] : w_fprod[63:32];
`endif
  end

  muldiv_step u_step (
    .acc          (r_acc),
    .operand      (r_opnd),
    .mcand_div    (r_divisor),
    .div_class    (r_op[2]),
    .acc_next     (w_step_acc),
    .operand_next (w_step_opnd)
  );

  // Sign fix-up is applied to the final step's outputs as CALC retires
  always_comb begin
    w_prod     = {w_step_acc, w_step_opnd};
    w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    w_quot     = r_neg_q ? (~w_step_opnd + 32'd1) : w_step_opnd;
    w_rem      = r_neg_r ? (~w_step_acc + 32'd1) : w_step_acc;
    case (r_op)
      OP_MUL:                    w_final = w_prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[63:32];
      OP_DIV, OP_DIVU:           w_final = w_quot;
      default:                   w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    MulDivBusy   = 1'b0;
    MulDivDone   = 1'b0;
    case (r_state)
      IDLE: begin
        MulDivBusy = w_accept;
        if (w_accept) w_next_state = w_short ? DONE : CALC;
      end
      CALC: begin
        MulDivBusy = 1'b1;
        if (FlushE)                 w_next_state = IDLE;
        else if (r_count == MD_LAST) w_next_state = DONE;
      end
      DONE: begin
        MulDivDone   = !FlushE;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= 6'd0;
      r_acc        <= 32'd0;
      r_opnd       <= 32'd0;
      r_divisor    <= 32'd0;
      r_op         <= OP_MUL;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      MulDivResult <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count   <= 6'd0;
            r_op      <= MulDivOpE;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_acc     <= 32'd0;
            r_opnd    <= w_div_op ? w_a_mag : w_b_mag;
            r_divisor <= w_div_op ? w_b_mag : w_a_mag;
            if (w_short) MulDivResult <= w_short_result;
          end
        end
        CALC: begin
          if (!FlushE) begin
            r_acc   <= w_step_acc;
            r_opnd  <= w_step_opnd;
            r_count <= r_count + 6'd1;
            if (r_count == MD_LAST) MulDivResult <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit with an
//               arithmetic reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MulDivE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        MulDivBusy;
  logic        MulDivDone;
  logic [31:0] MulDivResult;

  int          checks = 0;
  int          errors = 0;
  logic        check_en = 1'b0;
  logic        exp_busy;
  logic        exp_done;
  logic [31:0] exp_res;
  logic [31:0] prev_res;

  muldiv_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MulDivE      (MulDivE),
    .MulDivOpE    (MulDivOpE),
    .SrcAE        (SrcAE),
    .SrcBE        (SrcBE),
    .FlushE       (FlushE),
    .MulDivBusy   (MulDivBusy),
    .MulDivDone   (MulDivDone),
    .MulDivResult (MulDivResult)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] da, db;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    da = a;
    db = b;
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return da / db;
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return da % db;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      cmp("busy",   {31'd0, MulDivBusy}, {31'd0, exp_busy});
      cmp("done",   {31'd0, MulDivDone}, {31'd0, exp_done});
      cmp("result", MulDivResult, exp_res);
    end
  end

  // flush_at < 0: no flush; 0: flush in IDLE; 1..L-1: flush in CALC; L: flush in DONE
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input logic [31:0] lit);
    logic [31:0] r;
    int          l;
    int          end_c;
    bit          killed;
    r      = model(op, a, b);
    l      = lat(op, a, b);
    killed = (flush_at >= 0) && (flush_at < l);
    end_c  = killed ? flush_at + 1 : l + 1;
    if (!killed) cmp($sformatf("model op%0d a=%h b=%h", op, a, b), r, lit);
    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk); #1;
      if (c == end_c) begin
        MulDivE  = 1'b0;
        FlushE   = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_res  = prev_res;
      end else begin
        MulDivE   = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        FlushE    = (c == flush_at);
        exp_busy  = (c < l) && !(c == 0 && flush_at == 0);
        exp_done  = (c == l) && (flush_at != l);
        if (c == l) prev_res = r;
        exp_res   = prev_res;
      end
    end
  endtask

  task automatic reset_mid_div(input logic [31:0] a, input logic [31:0] b);
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      exp_done = 1'b0;
      if (c < 15) begin
        MulDivE = 1'b1; MulDivOpE = OP_DIV; SrcAE = a; SrcBE = b; FlushE = 1'b0;
        exp_busy = 1'b1;
        exp_res  = prev_res;
      end else if (c == 15) begin
        rst_n    = 1'b0;
        MulDivE  = 1'b0;
        exp_busy = 1'b1;
        exp_res  = prev_res;
      end else begin
        rst_n    = 1'b1;
        prev_res = 32'd0;
        exp_busy = 1'b0;
        exp_res  = 32'd0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; MulDivE = 1'b0; FlushE = 1'b0; MulDivOpE = OP_MUL;
    SrcAE = 32'd0; SrcBE = 32'd0;
    prev_res = 32'd0; exp_busy = 1'b0; exp_done = 1'b0; exp_res = 32'd0;
    repeat (2) @(posedge clk);
    #1 check_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         -1, 32'hFFFF_FFFD);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         -1, 32'hFFFF_FFFF);
    run_op(OP_DIVU,   32'd100,       32'd0,         -1, 32'hFFFF_FFFF);
    run_op(OP_REMU,   32'd100,       32'd0,         -1, 32'd100);
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000);
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'hFFFF_FFFE);
    run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'h0000_0001);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         -1, 32'hFFFF_FFFF);
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, -1, 32'h4000_0000);
    run_op(OP_MULH,   32'hFFFF_FFFD, 32'd5,         -1, 32'hFFFF_FFFF);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, -1, 32'hFFFF_FFFF);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'h8000_0000, -1, 32'h0000_0000);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'h8000_0000, -1, 32'h7FFF_FFFF);
    run_op(OP_MUL,    32'd7,         32'd6,         -1, 32'd42);
    run_op(OP_DIVU,   32'd1000,      32'd3,         10, 32'd0);
    run_op(OP_DIVU,   32'd9,         32'd3,         -1, 32'd3);
    run_op(OP_DIV,    32'd7,         32'hFFFF_FFFE, -1, 32'hFFFF_FFFD);
    run_op(OP_REM,    32'd7,         32'hFFFF_FFFE, -1, 32'd1);
    run_op(OP_REM,    32'hFFFF_FFFB, 32'd0,         -1, 32'hFFFF_FFFB);
    run_op(OP_DIV,    32'd5,         32'd0,         -1, 32'hFFFF_FFFF);
    run_op(OP_REMU,   32'hFFFF_FFFF, 32'd10,        -1, 32'd5);
    run_op(OP_DIVU,   32'hFFFF_FFFF, 32'd1,         -1, 32'hFFFF_FFFF);
    run_op(OP_DIVU,   32'd20,        32'd4,         33, 32'd5);
    run_op(OP_DIV,    32'd5,         32'd1,          0, 32'd0);
    reset_mid_div(32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         -1, 32'hFFFF_FFFD);
    run_op(OP_MULHU,  32'h0001_0000, 32'h0001_0000, -1, 32'h0000_0001);

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL expose ports, clock and reset first: clk in 1, system clock; rst_n in 1, reset.
REQ-002 SHALL use one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 SHALL expose MulDivE in 1: execute-stage instruction is an RV32M op.
REQ-004 SHALL expose MulDivOpE in 3: funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL expose SrcAE in 32 and SrcBE in 32: forwarded rs1 and rs2 operands.
REQ-006 SHALL expose FlushE in 1: execute-stage flush, which aborts the op in progress.
REQ-007 SHALL expose MulDivBusy out 1: stall request to the hazard logic for stages F, D and E.
REQ-008 SHALL expose MulDivDone out 1: result valid this cycle.
REQ-009 SHALL expose MulDivResult out 32: result, held until the next accepted op.

Function
REQ-010 SHALL implement FSM states IDLE, CALC and DONE.
REQ-011 IDLE to CALC SHALL occur when MulDivE=1 and FlushE=0; operands and op SHALL be latched, and the 6-bit iteration counter SHALL be cleared.
REQ-012 CALC SHALL run one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) on operand magnitudes.
REQ-013 CALC to DONE SHALL occur after exactly 32 steps (counter==31).
REQ-014 DONE to IDLE SHALL be unconditional; MulDivE seen in DONE SHALL NOT be accepted (it is the same instruction).
REQ-015 MulDivBusy SHALL be combinational: (IDLE & MulDivE & ~FlushE) | CALC; it SHALL be 0 in DONE so the pipeline advances.
REQ-016 Latency SHALL be: accept in cycle 0, CALC in cycles 1..32, MulDivDone=1 in cycle 33 only.
REQ-017 Sign handling SHALL be: DIV/REM/MULH use signed A and B; MULHSU uses signed A and unsigned B.
REQ-018 Sign correction SHALL be applied when leaving CALC; the quotient is negative iff signs differ, and the remainder takes the dividend's sign.
REQ-019 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the 64-bit result.
REQ-020 Divide by zero SHALL be detected in IDLE and SHALL go directly to DONE (latency 1): DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcAE.
REQ-021 Signed overflow (0x80000000 / -1) SHALL go directly to DONE: DIV returns 0x80000000; REM returns 0.
REQ-022 FlushE=1 in CALC SHALL return the FSM to IDLE next cycle, with MulDivDone not asserted and MulDivResult unchanged.
REQ-023 FlushE=1 in DONE SHALL suppress MulDivDone.
REQ-024 FlushE=1 with MulDivE=1 in IDLE SHALL not accept the op.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force IDLE, counter=0, MulDivResult=0, MulDivDone=0 and MulDivBusy=0, including in the middle of CALC.
REQ-026 The first op after reset release SHALL have the nominal latency.

Configuration
REQ-027 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU SHALL be computed by a single-cycle 33x33 signed multiplier and SHALL go IDLE to DONE (latency 1, no Busy in CALC); divides are unchanged.
REQ-028 Macro MULDIV_FAST_MUL_EN undefined: all eight ops SHALL take the 32-step CALC path, and no hardware multiplier SHALL be inferred.

Structure
REQ-029 Package muldiv_pkg SHALL hold: the state enum typedef (IDLE/CALC/DONE), the op-encoding localparams for funct3 values 0-7, and MD_ITER=32.
REQ-030 Sub-module muldiv_step SHALL be combinational; it SHALL take {acc, operand, multiplicand/divisor, op class} and return the next acc and operand for one radix-2 iteration.
REQ-031 The FSM, counter, sign fix-up and special-case detection SHALL reside in muldiv_unit.

Verification
REQ-032 DIV, A=-7 (0xFFFFFFF9), B=2: Busy SHALL be high for cycles 0..32 and Done SHALL be high in cycle 33 with result 0xFFFFFFFD (-3); REM on the same operands SHALL give 0xFFFFFFFF (-1).
REQ-033 DIVU with A=100, B=0 SHALL give Done in cycle 1 with result 0xFFFFFFFF; REMU with the same operands SHALL give 100.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF SHALL give Done in cycle 1 with result 0x80000000; REM on the same operands SHALL give 0.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFE; MUL on the same operands SHALL give 0x00000001; MULHSU -1 x 2 SHALL give 0xFFFFFFFF. Latency SHALL be 33 without MULDIV_FAST_MUL_EN and 1 with it.
REQ-036 DIVU 1000/3 with FlushE pulsed in cycle 10: the FSM SHALL return to IDLE in cycle 11, Done SHALL never assert, and the result SHALL keep its prior value; a new DIVU 9/3 SHALL then give 3 at the nominal latency.
REQ-037 rst_n low in cycle 15 of a DIV: all outputs SHALL be 0 the next cycle; MulDivE held high in DONE SHALL not start a second operation.
